sipo_param: RTL and testbench

SIPO_PARAM -- requirements
Module: sipo_param

---
 rtl/sipo_param.sv | 147 ++++++++++++++
 tb/tb_sipo_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_param.sv
// Serial-in / parallel-out converter with a double buffer.
// Words arrive on serial_in and are assembled into blocks of NUM_WORDS words in a
// shift stage. A complete block moves to a holding stage (parallel_out, full), where it
// stays until the consumer releases it with Rd. If the holding stage is still occupied
// when a block completes, the block waits in the shift stage, and the shift stage
// refuses further words until Rd frees the holding stage.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   reset        - synchronous active-high reset
//   Wr           - write strobe; serial_in is taken when Wr=1 and ready=1
//   serial_in    - IN_W-bit data word
//   Rd           - consumer acknowledge; releases the held block
//   clear        - aborts the partial block in the shift stage and clears overflow
//   parallel_out - held block (IN_W*NUM_WORDS bits)
//   full         - parallel_out holds an unread block
//   ready        - shift stage accepts words
//   count        - number of words held in the shift stage
//   overflow     - sticky flag: a write was dropped
module sipo_param #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              Wr,
    input  logic [IN_W-1:0]                   serial_in,
    input  logic                              Rd,
    input  logic                              clear,
    output logic [IN_W*NUM_WORDS-1:0]         parallel_out,
    output logic                              full,
    output logic                              ready,
    output logic [$clog2(NUM_WORDS+1)-1:0]    count,
    output logic                              overflow
);

    localparam int unsigned CW = $clog2(NUM_WORDS + 1);
    localparam int unsigned BW = IN_W * NUM_WORDS;
    localparam logic [CW-1:0] LastIdx = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] FullCnt = CW'(NUM_WORDS);

    typedef enum logic [0:0] {StFill, StPend} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   par_q, par_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;

    // Shift-stage contents with the incoming word inserted at the current position.
    logic [BW-1:0]   blk;
    int unsigned     pos;
    logic            transfer;

    always_comb begin
        blk = shift_q;
        pos = (MSB_FIRST != 0) ? (NUM_WORDS - 1 - 32'(count_q)) : 32'(count_q);
        // In PEND count equals NUM_WORDS, so only insert while filling.
        if (state_q == StFill) begin
            blk[pos*IN_W +: IN_W] = serial_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        par_d    = par_q;
        count_d  = count_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        transfer = 1'b0;

        if (clear) begin
            // Abort only the shift stage; Rd below still acts on the holding stage.
            count_d = '0;
            state_d = StFill;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                StFill: begin
                    if (Wr) begin
                        if (count_q == LastIdx) begin
                            if (!full_q || Rd) begin
                                par_d    = blk;
                                transfer = 1'b1;
                                count_d  = '0;
                            end else begin
                                shift_d = blk;
                                count_d = FullCnt;
                                state_d = StPend;
                            end
                        end else begin
                            shift_d = blk;
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                StPend: begin
                    // Writes are dropped here even when Rd frees the holding stage.
                    if (Wr) begin
                        ovf_d = 1'b1;
                    end
                    if (Rd) begin
                        par_d    = shift_q;
                        transfer = 1'b1;
                        count_d  = '0;
                        state_d  = StFill;
                    end
                end
                default: state_d = StFill;
            endcase
        end

        if (transfer) begin
            full_d = 1'b1;
        end else if (Rd && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFill;
            shift_q <= '0;
            par_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign parallel_out = par_q;
    assign full         = full_q;
    assign ready        = (state_q == StFill);
    assign count        = count_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_sipo_param.sv
// Bench for sipo_param: two instances (MSB_FIRST=1 and MSB_FIRST=0) share all inputs.
// A queue-based reference model predicts the post-edge outputs for every issued cycle;
// a monitor pops and compares after each rising edge.
module tb_sipo_param;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         Wr = 1'b0;
    logic [7:0]   serial_in = '0;
    logic         Rd = 1'b0;
    logic         clear = 1'b0;
    logic [127:0] p1, p0;
    logic         full1, full0, ready1, ready0, ovf1, ovf0;
    logic [4:0]   cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_param #(.IN_W(8), .NUM_WORDS(16), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .Wr(Wr), .serial_in(serial_in), .Rd(Rd), .clear(clear),
        .parallel_out(p1), .full(full1), .ready(ready1), .count(cnt1), .overflow(ovf1)
    );

    sipo_param #(.IN_W(8), .NUM_WORDS(16), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .Wr(Wr), .serial_in(serial_in), .Rd(Rd), .clear(clear),
        .parallel_out(p0), .full(full0), .ready(ready0), .count(cnt0), .overflow(ovf0)
    );

    typedef struct packed {
        logic [127:0] par1;
        logic [127:0] par0;
        logic         full;
        logic         ready;
        logic [4:0]   count;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    // Reference model: the shift stage is a list of words, the holding stage a value.
    logic [7:0]   words[$];
    logic [127:0] held1 = '0;
    logic [127:0] held0 = '0;
    bit           mfull = 1'b0;
    bit           movf = 1'b0;

    function automatic logic [127:0] pack(input bit msb);
        logic [127:0] v = '0;
        for (int i = 0; i < words.size(); i++) begin
            if (msb) v = {v[119:0], words[i]};
            else     v = v | (128'(words[i]) << (8 * i));
        end
        return v;
    endfunction

    task automatic model(input bit r, input bit w, input bit rd, input bit c,
                         input logic [7:0] d);
        bit moved = 1'b0;
        bit rd_hit = rd && mfull;
        if (r) begin
            words.delete();
            held1 = '0;
            held0 = '0;
            mfull = 1'b0;
            movf  = 1'b0;
            return;
        end
        if (c) begin
            words.delete();
            movf = 1'b0;
        end else if (words.size() == 16) begin
            if (w) movf = 1'b1;
            if (rd) begin
                held1 = pack(1'b1);
                held0 = pack(1'b0);
                words.delete();
                moved = 1'b1;
            end
        end else if (w) begin
            words.push_back(d);
            if (words.size() == 16 && (!mfull || rd)) begin
                held1 = pack(1'b1);
                held0 = pack(1'b0);
                words.delete();
                moved = 1'b1;
            end
        end
        if (moved) mfull = 1'b1;
        else if (rd_hit) mfull = 1'b0;
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input bit c,
                        input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        reset = r; Wr = w; Rd = rd; clear = c; serial_in = d;
        model(r, w, rd, c, d);
        e.par1  = held1;
        e.par0  = held0;
        e.full  = mfull;
        e.ready = (words.size() < 16);
        e.count = 5'(words.size());
        e.ovf   = movf;
        sb.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, base + 8'(i));
    endtask

    // Wait until the last issued cycle has been clocked into the DUTs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] base, input bit msb);
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) begin
            if (msb) v = {v[119:0], base + 8'(i)};
            else     v = v | (128'(base + 8'(i)) << (8 * i));
        end
        return v;
    endfunction

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            checks++;
            if (p1 !== me.par1 || p0 !== me.par0 || full1 !== me.full || full0 !== me.full ||
                ready1 !== me.ready || ready0 !== me.ready || cnt1 !== me.count ||
                cnt0 !== me.count || ovf1 !== me.ovf || ovf0 !== me.ovf) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got p1=%h p0=%h f=%b/%b r=%b/%b c=%0d/%0d o=%b/%b expected p1=%h p0=%h f=%b r=%b c=%0d o=%b",
                         $time, p1, p0, full1, full0, ready1, ready0, cnt1, cnt0, ovf1, ovf0,
                         me.par1, me.par0, me.full, me.ready, me.count, me.ovf);
            end
        end
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        settle();
        chk("reset_par", p1, '0);
        chk("reset_full_ready_count_ovf", {full1, ready1, cnt1, ovf1}, {1'b0, 1'b1, 5'd0, 1'b0});

        // First block, both word orders
        wr_words(16, 8'h00);
        settle();
        chk("block_msb", p1, 128'h000102030405060708090A0B0C0D0E0F);
        chk("block_lsb", p0, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("block_full_count", {full1, cnt1}, {1'b1, 5'd0});

        // Second block with no Rd goes to PEND
        wr_words(16, 8'h10);
        settle();
        chk("pend_ready_count", {ready1, cnt1}, {1'b0, 5'd16});
        chk("pend_par_kept", p1, 128'h000102030405060708090A0B0C0D0E0F);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
        settle();
        chk("pend_overflow", ovf1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        chk("pend_release_par", p1, 128'h101112131415161718191A1B1C1D1E1F);
        chk("pend_release_flags", {full1, ready1, cnt1}, {1'b1, 1'b1, 5'd0});

        // Rd on the same edge as the last word: direct transfer
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        wr_words(15, 8'h30);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h3F);
        settle();
        chk("same_edge_par", p1, ramp(8'h30, 1'b1));
        chk("same_edge_flags", {full1, ready1, cnt1, ovf1}, {1'b1, 1'b1, 5'd0, 1'b0});

        // clear with overflow set and a partial block
        wr_words(16, 8'h40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        wr_words(5, 8'h50);
        settle();
        chk("pre_clear", {cnt1, ovf1}, {5'd5, 1'b1});
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        settle();
        chk("clear_flags", {full1, cnt1, ovf1}, {1'b1, 5'd0, 1'b0});
        chk("clear_par", p1, held1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
        settle();
        chk("clear_wr_count", cnt1, 5'd0);

        // Reset mid-block, then a clean block
        wr_words(7, 8'h90);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h97);
        settle();
        chk("mid_reset", {p1, full1, cnt1}, {128'h0, 1'b0, 5'd0});
        wr_words(16, 8'h60);
        settle();
        chk("after_reset_msb", p1, ramp(8'h60, 1'b1));
        chk("after_reset_lsb", p0, ramp(8'h60, 1'b0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 10) < 7, ($urandom % 4) == 0,
                 ($urandom % 40) == 0, 8'($urandom));
        end
        idle();
        idle();
        settle();
        settle();
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
